// File: rtl/screen_defs.sv
// ============================================================================
// Module   : screen_defs (package)
// Purpose  : Screen state encodings and winner codes shared with game logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package screen_defs;

  typedef enum logic [1:0] {
    WELCOME = 2'b00,
    PLAY    = 2'b01,
    SCORE   = 2'b10
  } screen_state_e;

  localparam logic [1:0] c_win_draw     = 2'b00;
  localparam logic [1:0] c_win_x        = 2'b01;
  localparam logic [1:0] c_win_o        = 2'b10;
  localparam logic [1:0] c_win_draw_alt = 2'b11;

  localparam int SCORE_W = 4;

  // Increment that holds at the limit instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value,
                                                 input logic [SCORE_W-1:0] limit);
    return (value >= limit) ? value : value + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// ============================================================================
// Module   : rise_detect
// Purpose  : One-cycle pulse on a rising edge of a level input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic r_prev;

  // Previous value resets high so a level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= in;
    end
  end

  assign pulse = in & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/screen_sequencer.sv
// ============================================================================
// Module   : screen_sequencer
// Purpose  : Welcome / play / score screen sequencing with win tallies.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module screen_sequencer
  import screen_defs::*;
#(
  parameter int SCORE_FRAMES = 180,
  parameter int MAX_SCORE    = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               btn_start,
  input  logic               game_over,
  input  logic [1:0]         winner,
  output logic               ceWS,
  output logic               cePS,
  output logic               ceSS,
  output logic               game_clr,
  output logic [SCORE_W-1:0] score_x,
  output logic [SCORE_W-1:0] score_o
);

  localparam int                   c_cnt_w      = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;
  localparam logic [c_cnt_w-1:0]   c_last_frame = c_cnt_w'(SCORE_FRAMES - 1);
  localparam logic [SCORE_W-1:0]   c_max_score  = SCORE_W'(MAX_SCORE);

  screen_state_e        r_state;
  screen_state_e        w_next_state;
  logic                 w_start;
  logic                 w_expire;
  logic                 w_accept_over;
  logic                 w_enter_play;
  logic                 r_game_clr;
  logic [c_cnt_w-1:0]   r_frame_cnt;
  logic [SCORE_W-1:0]   r_score_x;
  logic [SCORE_W-1:0]   r_score_o;

  rise_detect u_start_edge (
    .clk   (clk),
    .reset (reset),
    .in    (btn_start),
    .pulse (w_start)
  );

  assign w_expire      = frame_tick && (r_frame_cnt == c_last_frame);
  assign w_accept_over = (r_state == PLAY) && game_over;

  always_comb begin
    w_next_state = r_state;
    w_enter_play = 1'b0;
    case (r_state)
      WELCOME: begin
        if (w_start) begin
          w_next_state = PLAY;
        end
      end
      PLAY: begin
        if (game_over) begin
          w_next_state = SCORE;
        end
      end
      SCORE: begin
        // A start edge wins over a coincident timer expiry.
        if (w_start) begin
          w_next_state = PLAY;
        end else if (w_expire) begin
          w_next_state = WELCOME;
        end
      end
      default: begin
        w_next_state = WELCOME;
      end
    endcase
    w_enter_play = (w_next_state == PLAY) && (r_state != PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= WELCOME;
      r_game_clr <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_game_clr <= w_enter_play;
    end
  end

  // Held at zero outside SCORE, which also clears it on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (r_state != SCORE) begin
      r_frame_cnt <= '0;
    end else if (frame_tick) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_score_x <= '0;
      r_score_o <= '0;
    end else if (w_accept_over) begin
      case (winner)
        c_win_x:        r_score_x <= sat_inc(r_score_x, c_max_score);
        c_win_o:        r_score_o <= sat_inc(r_score_o, c_max_score);
        c_win_draw,
        c_win_draw_alt: begin
          r_score_x <= r_score_x;
          r_score_o <= r_score_o;
        end
        default: begin
          r_score_x <= r_score_x;
          r_score_o <= r_score_o;
        end
      endcase
    end
  end

  // Unused encoding 2'b11 falls back to the welcome screen so one enable is always high.
  assign cePS     = (r_state == PLAY);
  assign ceSS     = (r_state == SCORE);
  assign ceWS     = (r_state != PLAY) && (r_state != SCORE);
  assign game_clr = r_game_clr;
  assign score_x  = r_score_x;
  assign score_o  = r_score_o;

endmodule

`default_nettype wire

// File: tb/tb_screen_sequencer.sv
// ============================================================================
// Module   : tb_screen_sequencer
// Purpose  : Directed and random checks against a screen-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_screen_sequencer;

  localparam int SCORE_FRAMES = 4;
  localparam int MAX_SCORE    = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       btn_start;
  logic       game_over;
  logic [1:0] winner;
  logic       ceWS, cePS, ceSS, game_clr;
  logic [3:0] score_x, score_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: screen 0=welcome, 1=play, 2=score.
  int m_scr    = 0;
  int m_frames = 0;
  int m_sx     = 0;
  int m_so     = 0;
  bit m_prev   = 1'b1;
  bit m_clr    = 1'b0;

  screen_sequencer #(
    .SCORE_FRAMES (SCORE_FRAMES),
    .MAX_SCORE    (MAX_SCORE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_start  (btn_start),
    .game_over  (game_over),
    .winner     (winner),
    .ceWS       (ceWS),
    .cePS       (cePS),
    .ceSS       (ceSS),
    .game_clr   (game_clr),
    .score_x    (score_x),
    .score_o    (score_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit start_edge;
    if (reset) begin
      m_scr = 0; m_frames = 0; m_sx = 0; m_so = 0; m_prev = 1'b1; m_clr = 1'b0;
    end else begin
      start_edge = btn_start && !m_prev;
      m_prev     = btn_start;
      m_clr      = 1'b0;
      if (m_scr == 0) begin
        if (start_edge) begin m_scr = 1; m_clr = 1'b1; end
      end else if (m_scr == 1) begin
        if (game_over) begin
          if (winner == 2'b01 && m_sx < MAX_SCORE) m_sx++;
          if (winner == 2'b10 && m_so < MAX_SCORE) m_so++;
          m_scr = 2; m_frames = 0;
        end
      end else begin
        if (frame_tick) m_frames++;
        if (start_edge) begin m_scr = 1; m_clr = 1'b1; end
        else if (m_frames == SCORE_FRAMES) m_scr = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ceWS", ceWS, 8'(m_scr == 0));
      check("cePS", cePS, 8'(m_scr == 1));
      check("ceSS", ceSS, 8'(m_scr == 2));
      check("game_clr", game_clr, 8'(m_clr));
      check("score_x", score_x, 8'(m_sx));
      check("score_o", score_o, 8'(m_so));
    end
  end

  task automatic press();
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
  endtask

  task automatic finish_game(input logic [1:0] w);
    game_over = 1'b1;
    winner    = w;
    @(negedge clk);
    game_over = 1'b0;
    winner    = 2'b00;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; btn_start = 1'b1; frame_tick = 1'b0; game_over = 1'b0; winner = 2'b00;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ws", ceWS, 1);
    check("rst_clr", game_clr, 0);
    check("rst_sx", score_x, 0);

    // Button held across reset release must not start a game.
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("held_ws", ceWS, 1);
    btn_start = 1'b0;
    @(negedge clk);

    press();
    check("start_ps", cePS, 1);
    check("start_clr", game_clr, 1);
    @(negedge clk);
    check("clr_once", game_clr, 0);

    finish_game(2'b01);
    check("over_ss", ceSS, 1);
    check("over_sx", score_x, 1);

    repeat (3) begin tick(); @(negedge clk); end
    check("tick3_ss", ceSS, 1);
    tick();
    check("tick4_ws", ceWS, 1);

    press();
    finish_game(2'b10);
    repeat (3) begin tick(); @(negedge clk); end
    frame_tick = 1'b1;
    press();
    frame_tick = 1'b0;
    check("race_ps", cePS, 1);
    check("race_clr", game_clr, 1);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    press();
    repeat (11) begin
      @(negedge clk);
      finish_game(2'b10);
      press();
    end
    check("sat_so", score_o, 9);
    check("sat_sx", score_x, 0);
    finish_game(2'b11);
    check("draw_ss", ceSS, 1);
    check("draw_so", score_o, 9);
    check("draw_sx", score_x, 0);

    press();
    reset = 1'b1; game_over = 1'b1; winner = 2'b01;
    @(negedge clk);
    reset = 1'b0; game_over = 1'b0; winner = 2'b00;
    check("rstp_ws", ceWS, 1);
    check("rstp_so", score_o, 0);
    @(negedge clk);
    check("rstp_noss", ceSS, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) btn_start = ~btn_start;
      frame_tick = ($urandom_range(0, 2) == 0);
      game_over  = ($urandom_range(0, 5) == 0);
      winner     = 2'($urandom_range(0, 3));
      reset      = ($urandom_range(0, 249) == 0);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
